// File: rtl/sender_pkg.sv
// Shared definitions for the serial frame Sender and its upstream arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sender_pkg;

    // Sender frame width and the cycles one frame occupies (1 READY + 42 SEND)
    localparam int FRAME_W    = 40;
    localparam int SENDER_GAP = 43;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    // WAIT-counter load giving exactly `gap` cycles between issue pulses:
    // ISSUE (1) + WAIT (load+1) + IDLE handshake (1) = gap.
    function automatic int gap_load(input int gap);
        return (gap > 3) ? (gap - 3) : 0;
    endfunction

endpackage

// File: rtl/sender_arbiter_if.sv
// Requester/Sender-side bundle of the sender arbiter.
// Latency: n/a (wires only).
// Backpressure: req_ready is the grant; out_valid is a bare pulse with no ready.
interface sender_arbiter_if #(
    parameter int N_REQ   = 3,
    parameter int FRAME_W = sender_pkg::FRAME_W
);
    logic [N_REQ-1:0]         req_valid;
    logic [N_REQ*FRAME_W-1:0] req_data;
    logic [N_REQ-1:0]         req_ready;
    logic [FRAME_W-1:0]       out_data;
    logic                     out_valid;
    logic                     sender_loss;
    logic                     clear_err;
    logic                     busy;
    logic [2:0]               grant_id;
    logic                     loss_err;

    // Environment side: requesters plus the Sender's loss flag
    modport master (
        output req_valid, req_data, sender_loss, clear_err,
        input  req_ready, out_data, out_valid, busy, grant_id, loss_err
    );

    // Arbiter side
    modport slave (
        input  req_valid, req_data, sender_loss, clear_err,
        output req_ready, out_data, out_valid, busy, grant_id, loss_err
    );
endinterface

// File: rtl/sender_arbiter_rr_pick.sv
// Round-robin winner search: first set request above ptr, wrapping to 0.
// Latency: purely combinational.
// Backpressure: none; any=0 when no request is pending.
module rr_pick #(
    parameter int N_REQ = 3,
    parameter int IDX_W = 3
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Two passes: indices above ptr first, then the wrapped range 0..ptr
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int j = 0; j < N_REQ; j++) begin
            if (!any && (j > int'(ptr)) && req[j]) begin
                gnt[j] = 1'b1;
                idx    = IDX_W'(j);
                any    = 1'b1;
            end
        end
        for (int j = 0; j < N_REQ; j++) begin
            if (!any && (j <= int'(ptr)) && req[j]) begin
                gnt[j] = 1'b1;
                idx    = IDX_W'(j);
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sender_arbiter.sv
// Round-robin arbiter sharing one serial frame Sender between N_REQ requesters.
// Latency: out_valid pulses 1 cycle after the req handshake; pulses >= GAP_CYCLES apart.
// Backpressure: req_ready only in IDLE; SENDER_ARB_PRIO0_EN gives requester 0 absolute priority.
module sender_arbiter
    import sender_pkg::*;
#(
    parameter int N_REQ      = 3,
    parameter int FRAME_W    = sender_pkg::FRAME_W,
    parameter int GAP_CYCLES = SENDER_GAP
) (
    input  logic           clk,
    input  logic           n_reset,
    sender_arbiter_if.slave bus
);

    localparam int IDX_W = 3;
    localparam int CNT_W = $clog2(GAP_CYCLES) + 1;
    localparam int LOAD  = gap_load(GAP_CYCLES);
    localparam logic [IDX_W-1:0] PTR_RST = IDX_W'(N_REQ - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   grant_q, grant_d;
    logic [FRAME_W-1:0] out_data_q, out_data_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;
    logic               loss_q, loss_d;
    // Keeps req_ready low while reset is held, even with requests pending
    logic               arm_q, arm_d;

    logic [N_REQ-1:0]   rr_gnt;
    logic [IDX_W-1:0]   rr_idx;
    logic               rr_any;

    logic [N_REQ-1:0]   win_gnt;
    logic [IDX_W-1:0]   win_idx;
    logic               win_any;
    logic               win_upd_ptr;
    logic               take;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req (bus.req_valid),
        .ptr (ptr_q),
        .gnt (rr_gnt),
        .idx (rr_idx),
        .any (rr_any)
    );

`ifdef SENDER_ARB_PRIO0_EN
    // Requester 0 pre-empts the rotation and leaves the pointer untouched
    always_comb begin
        win_any = rr_any;
        if (bus.req_valid[0]) begin
            win_gnt     = {{(N_REQ-1){1'b0}}, 1'b1};
            win_idx     = '0;
            win_upd_ptr = 1'b0;
        end else begin
            win_gnt     = rr_gnt;
            win_idx     = rr_idx;
            win_upd_ptr = 1'b1;
        end
    end
`else
    // Pure round-robin across all requesters
    always_comb begin
        win_any     = rr_any;
        win_gnt     = rr_gnt;
        win_idx     = rr_idx;
        win_upd_ptr = 1'b1;
    end
`endif

    // Grant is offered only in IDLE; the winner is valid by construction,
    // so an offered grant is always a transfer on the next edge
    assign take          = (state_q == IDLE) && arm_q && win_any;
    assign bus.req_ready = take ? win_gnt : '0;

    // Next-state, counter, frame latch and sticky error computation
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        arm_d       = 1'b1;

        case (state_q)
            IDLE: begin
                if (take) begin
                    out_data_d  = bus.req_data[int'(win_idx)*FRAME_W +: FRAME_W];
                    grant_d     = win_idx;
                    if (win_upd_ptr) begin
                        ptr_d = win_idx;
                    end
                    out_valid_d = 1'b1;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (GAP_CYCLES > 2) begin
                    cnt_d   = CNT_W'(LOAD);
                    state_d = WAIT;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);

        // A new loss in the same cycle as a clear must not be lost
        if (bus.sender_loss) begin
            loss_d = 1'b1;
        end else if (bus.clear_err) begin
            loss_d = 1'b0;
        end else begin
            loss_d = loss_q;
        end
    end

    // FSM and output registers
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ptr_q       <= PTR_RST;
            grant_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            loss_q      <= 1'b0;
            arm_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            loss_q      <= loss_d;
            arm_q       <= arm_d;
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.grant_id  = grant_q;
    assign bus.loss_err  = loss_q;

endmodule

// File: tb/tb_sender_arbiter.sv
// Directed bench for sender_arbiter with a grant/frame scoreboard.
// Latency: n/a.
// Backpressure: requesters hold valid until granted, then drop or reload.
module tb_sender_arbiter;

    localparam int N   = 3;
    localparam int FW  = 40;
    localparam int GAP = 43;

    typedef struct packed {
        logic [2:0]    id;
        logic [FW-1:0] dat;
    } exp_t;

    logic clk = 1'b0;
    logic n_reset = 1'b0;

    sender_arbiter_if #(.N_REQ(N), .FRAME_W(FW)) bus ();

    sender_arbiter #(
        .N_REQ      (N),
        .FRAME_W    (FW),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk     (clk),
        .n_reset (n_reset),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    int       checks = 0;
    int       failures = 0;
    int       cyc = 0;
    int       npulse = 0;
    int       busy_cnt = 0;
    int       frm [N];
    logic [N-1:0] keep = '0;
    logic [N-1:0] hs = '0;
    logic     prev_ov = 1'b0;
    exp_t     exp_q [$];
    int       pulse_cyc [$];

    function automatic logic [FW-1:0] mk(input int i, input int k);
        return {8'(8'hA0 + i), 32'(k)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int id, input logic [FW-1:0] dat);
        exp_t e;
        e.id  = 3'(id);
        e.dat = dat;
        exp_q.push_back(e);
    endtask

    // One clock: capture handshakes, let requesters react, then monitor at negedge
    task automatic tick();
        exp_t e;
        #1;
        hs = bus.req_valid & bus.req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (hs[i]) begin
                if (keep[i]) begin
                    frm[i]++;
                    bus.req_data[i*FW +: FW] = mk(i, frm[i]);
                end else begin
                    bus.req_valid[i] = 1'b0;
                end
            end
        end
        @(negedge clk);
        cyc++;
        if (bus.busy) busy_cnt++;
        if (bus.out_valid) begin
            chk("out_valid_single_cycle", 64'(prev_ov), 64'd0);
            chk("sb_has_entry", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("sb_out_data", 64'(bus.out_data), 64'(e.dat));
                chk("sb_grant_id", 64'(bus.grant_id), 64'(e.id));
            end
            pulse_cyc.push_back(cyc);
            npulse++;
        end
        prev_ov = bus.out_valid;
    endtask

    task automatic run_pulses(input int n);
        int target;
        int budget;
        target = npulse + n;
        budget = n * 60 + 20;
        while (npulse < target && budget > 0) begin
            tick();
            budget--;
        end
        chk("pulse_wait_timeout", 64'(npulse >= target), 64'd1);
    endtask

    task automatic drain();
        int budget;
        budget = 100;
        while (bus.busy && budget > 0) begin
            tick();
            budget--;
        end
        chk("drain_timeout", 64'(bus.busy), 64'd0);
    endtask

    task automatic chk_gaps(input int first, input int last);
        for (int p = first + 1; p <= last; p++) begin
            chk("issue_gap", 64'(pulse_cyc[p] - pulse_cyc[p-1]), 64'(GAP));
        end
    endtask

    initial begin
        int base;
        bus.req_valid   = '0;
        bus.sender_loss = 1'b0;
        bus.clear_err   = 1'b0;
        for (int i = 0; i < N; i++) begin
            frm[i] = 0;
            bus.req_data[i*FW +: FW] = mk(i, 0);
        end

        // Reset values
        repeat (3) @(negedge clk);
        bus.req_valid = 3'b111;
        #1;
        chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
        bus.req_valid = '0;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_data", 64'(bus.out_data), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_grant_id", 64'(bus.grant_id), 64'd0);
        chk("rst_loss_err", 64'(bus.loss_err), 64'd0);
        @(negedge clk);
        n_reset = 1'b1;
        tick();

        // All requesters valid continuously
        base = npulse;
        bus.req_valid = 3'b111;
        keep = 3'b111;
`ifdef SENDER_ARB_PRIO0_EN
        for (int k = 0; k < 4; k++) push_exp(0, mk(0, k));
        run_pulses(4);
        bus.req_valid[0] = 1'b0;
        keep[0] = 1'b0;
        push_exp(1, mk(1, 0));
        push_exp(2, mk(2, 0));
        push_exp(1, mk(1, 1));
        run_pulses(3);
        chk_gaps(base, base + 6);
`else
        push_exp(0, mk(0, 0));
        push_exp(1, mk(1, 0));
        push_exp(2, mk(2, 0));
        push_exp(0, mk(0, 1));
        run_pulses(4);
        chk_gaps(base, base + 3);
`endif
        bus.req_valid = '0;
        keep = '0;
        drain();

        // Single request: busy spans ISSUE plus WAIT, i.e. GAP-1 cycles
        tick();
        busy_cnt = 0;
        bus.req_data[1*FW +: FW] = 40'hD999999991;
        bus.req_valid = 3'b010;
        #1;
        chk("single_req_ready", 64'(bus.req_ready), 64'b010);
        push_exp(1, 40'hD999999991);
        run_pulses(1);
        chk("single_ready_after", 64'(bus.req_ready), 64'd0);
        chk("single_valid_dropped", 64'(bus.req_valid), 64'd0);
        drain();
        chk("single_busy_cycles", 64'(busy_cnt), 64'(GAP - 1));
        chk("single_out_data_hold", 64'(bus.out_data), 64'h00D999999991);
        chk("single_grant_hold", 64'(bus.grant_id), 64'd1);

        // Late requester 2 joins during WAIT while requester 0 keeps asking
        bus.req_valid = 3'b001;
        keep = 3'b001;
        push_exp(0, mk(0, frm[0]));
        run_pulses(1);
        repeat (10) tick();
        chk("late_in_wait", 64'(bus.busy), 64'd1);
        bus.req_valid[2] = 1'b1;
        keep[2] = 1'b1;
`ifdef SENDER_ARB_PRIO0_EN
        push_exp(0, mk(0, frm[0]));
        push_exp(0, mk(0, frm[0] + 1));
`else
        push_exp(2, mk(2, frm[2]));
        push_exp(0, mk(0, frm[0]));
`endif
        run_pulses(2);

        // Asynchronous reset in the middle of WAIT
        repeat (5) tick();
        chk("pre_reset_busy", 64'(bus.busy), 64'd1);
        #2;
        n_reset = 1'b0;
        #1;
        chk("async_rst_busy", 64'(bus.busy), 64'd0);
        chk("async_rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("async_rst_req_ready", 64'(bus.req_ready), 64'd0);
        chk("async_rst_grant_id", 64'(bus.grant_id), 64'd0);
        repeat (2) tick();
        n_reset = 1'b1;
        push_exp(0, mk(0, frm[0]));
        run_pulses(1);
        bus.req_valid = '0;
        keep = '0;
        drain();

        // Sticky loss flag: set, hold, clear, set-beats-clear
        bus.sender_loss = 1'b1;
        tick();
        bus.sender_loss = 1'b0;
        chk("loss_set", 64'(bus.loss_err), 64'd1);
        repeat (3) tick();
        chk("loss_hold", 64'(bus.loss_err), 64'd1);
        bus.clear_err = 1'b1;
        tick();
        bus.clear_err = 1'b0;
        chk("loss_clear", 64'(bus.loss_err), 64'd0);
        bus.sender_loss = 1'b1;
        bus.clear_err = 1'b1;
        tick();
        chk("loss_set_wins_from_0", 64'(bus.loss_err), 64'd1);
        tick();
        bus.sender_loss = 1'b0;
        bus.clear_err = 1'b0;
        chk("loss_set_wins_from_1", 64'(bus.loss_err), 64'd1);
        bus.clear_err = 1'b1;
        tick();
        bus.clear_err = 1'b0;
        chk("loss_clear_again", 64'(bus.loss_err), 64'd0);

        chk("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
